// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a five-stage MIPS-style core. It combines two
// stall sources:
//   * data stall : a Decode source register that a younger result in Execute
//                  or Memory will not produce in time (Tuse/Tnew comparison);
//   * md stall   : a Decode instruction touching HI/LO or starting mult/div
//                  while the mult/div unit is occupied or being started.
// A single stall freezes PC and F/D and injects a bubble into D/E.
//
// The mult/div occupancy is tracked by a two-state FSM (IDLE/BUSY) with a
// 4-bit down-counter: 5 busy cycles for mult, 10 for div.
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   -> stall_cnt is a 32-bit wrapping counter of stall cycles
//   undefined -> stall_cnt is constant 0 and no counter is built
//
// Ports
//   clk                   in   system clock
//   reset                 in   synchronous, active-high reset
//   D_rs, D_rt            in 5 Decode source register numbers
//   D_tuse_rs, D_tuse_rt  in 2 cycles until Decode needs rs/rt (3 = never)
//   E_dst, M_dst          in 5 Execute/Memory destination (0 = none)
//   E_tnew, M_tnew        in 2 cycles until the E/M result is produced
//   D_is_md               in   Decode instruction uses HI/LO or mult/div
//   E_md_start            in   mult/div issued from Execute this cycle
//   E_md_op               in   0 = mult, 1 = div
//   PC_en, FD_en          out  PC and F/D register enables
//   DE_flush              out  bubble insert into D/E
//   md_busy               out  mult/div unit occupied
//   stall_cnt             out 32 stall statistics
//   o_dbg_state           out  FSM state (0 = IDLE, 1 = BUSY)
// ----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic [4:0]  E_dst,
    input  logic [4:0]  M_dst,
    input  logic [1:0]  E_tnew,
    input  logic [1:0]  M_tnew,
    input  logic        D_is_md,
    input  logic        E_md_start,
    input  logic        E_md_op,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_flush,
    output logic        md_busy,
    output logic [31:0] stall_cnt,
    output logic        o_dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_md_cnt;
    logic [3:0] w_md_cnt_next;

    logic       w_rs_stall;
    logic       w_rt_stall;
    logic       w_data_stall;
    logic       w_md_stall;
    logic       w_stall;

    // ------------------------------------------------------------------
    // FSM state register (reset wins over a simultaneous E_md_start)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_md_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        case (r_state)
            ST_IDLE: begin
                if (E_md_start) begin
                    w_state_next  = ST_BUSY;
                    w_md_cnt_next = E_md_op ? DIV_CYCLES : MULT_CYCLES;
                end
            end
            ST_BUSY: begin
                // A new start while busy is ignored: no reload.
                w_md_cnt_next = r_md_cnt - 4'd1;
                // The count==0 case is unreachable; leaving BUSY there keeps
                // a corrupted counter from wedging the unit busy for 16 cycles.
                if (r_md_cnt <= 4'd1) begin
                    w_state_next  = ST_IDLE;
                    w_md_cnt_next = 4'd0;
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_md_cnt_next = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs and stall combination
    // ------------------------------------------------------------------
    always_comb begin
        // A source only stalls when a matching producer needs more cycles
        // than the consumer can wait. Register 0 is hardwired and never waits.
        w_rs_stall = (D_rs != 5'd0) &&
                     (((D_rs == E_dst) && (E_tnew > D_tuse_rs)) ||
                      ((D_rs == M_dst) && (M_tnew > D_tuse_rs)));
        w_rt_stall = (D_rt != 5'd0) &&
                     (((D_rt == E_dst) && (E_tnew > D_tuse_rt)) ||
                      ((D_rt == M_dst) && (M_tnew > D_tuse_rt)));
        w_data_stall = w_rs_stall || w_rt_stall;

        // Starting mult/div in Execute blocks HI/LO users the same cycle,
        // before the FSM has registered BUSY.
        w_md_stall = D_is_md && ((r_state == ST_BUSY) || E_md_start);

        w_stall  = !reset && (w_data_stall || w_md_stall);

        PC_en       = !w_stall;
        FD_en       = !w_stall;
        DE_flush    = w_stall;
        md_busy     = !reset && (r_state == ST_BUSY);
        o_dbg_state = r_state;
    end

    // ------------------------------------------------------------------
    // Stall statistics
    // ------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;

    // w_stall is already gated by reset; coinciding stall sources count once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Inputs are driven 1 time unit after the
// rising edge, outputs are sampled on the falling edge. Expected output
// vectors {PC_en, FD_en, DE_flush, md_busy} are pushed into exp_q when a cycle
// is driven and popped when the cycle is sampled. Build with
// +define+HAZARD_STATS_EN to exercise the statistics counter.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  D_rs, D_rt, E_dst, M_dst;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_is_md, E_md_start, E_md_op;
    logic        PC_en, FD_en, DE_flush, md_busy;
    logic [31:0] stall_cnt;
    logic        dbg_state;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .E_dst      (E_dst),
        .M_dst      (M_dst),
        .E_tnew     (E_tnew),
        .M_tnew     (M_tnew),
        .D_is_md    (D_is_md),
        .E_md_start (E_md_start),
        .E_md_op    (E_md_op),
        .PC_en      (PC_en),
        .FD_en      (FD_en),
        .DE_flush   (DE_flush),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt),
        .o_dbg_state(dbg_state)
    );

    logic [3:0] obs;
    assign obs = {PC_en, FD_en, DE_flush, md_busy};

    // ---------------- scoreboard ----------------
    logic [3:0]  exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_cnt = 32'd0;   // model of stall_cnt with stats enabled
    int          seen_stalls = 0;   // observed DE_flush cycles

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected output vector for a given stall / busy pair.
    function automatic logic [3:0] vec(input logic s, input logic b);
        return {~s, ~s, s, b};
    endfunction

    // Reference data-hazard rule.
    function automatic logic ref_stall(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [1:0] urs, input logic [1:0] urt,
                                       input logic [4:0] ed, input logic [4:0] md,
                                       input logic [1:0] te, input logic [1:0] tm);
        logic a, b;
        a = (rs != 0) && ((rs == ed && te > urs) || (rs == md && tm > urs));
        b = (rt != 0) && ((rt == ed && te > urt) || (rt == md && tm > urt));
        return a | b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_data(input logic [4:0] rs, input logic [4:0] rt,
                            input logic [1:0] urs, input logic [1:0] urt,
                            input logic [4:0] ed, input logic [4:0] md,
                            input logic [1:0] te, input logic [1:0] tm);
        D_rs = rs; D_rt = rt; D_tuse_rs = urs; D_tuse_rt = urt;
        E_dst = ed; M_dst = md; E_tnew = te; M_tnew = tm;
    endtask

    task automatic set_md(input logic is_md, input logic start, input logic op);
        D_is_md = is_md; E_md_start = start; E_md_op = op;
    endtask

    // One clock cycle: push the expectation, compare on the falling edge,
    // then advance to just after the next rising edge.
    task automatic cycle(input string tag, input logic [3:0] e);
        logic [3:0] want;
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        check(tag, 32'(obs), 32'(want));
        if (DE_flush) seen_stalls++;
        @(posedge clk);
        if (reset) exp_cnt = 32'd0;
        else if (e[1]) exp_cnt = exp_cnt + 32'd1;
        #1;
    endtask

    function automatic logic [31:0] cnt_exp();
        return STATS ? exp_cnt : 32'd0;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] rs, rt, ed, md;
        logic [1:0] urs, urt, te, tm;

        // Reset held with a hazard and a mult/div start present: all forced off.
        reset = 1'b1;
        set_data(5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 5'd0, 2'd2, 2'd0);
        set_md(1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        cycle("rst_out", vec(1'b0, 1'b0));
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        reset = 1'b0;
        set_md(1'b0, 1'b0, 1'b0);

        // Load-use on rs from Execute.
        set_data(5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 5'd0, 2'd2, 2'd0);
        cycle("load_use", vec(1'b1, 1'b0));
        // Register 0 never stalls.
        set_data(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 2'd2, 2'd0);
        cycle("zero_reg", vec(1'b0, 1'b0));
        // rt hazard from Memory.
        set_data(5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 5'd9, 2'd0, 2'd1);
        cycle("m_rt", vec(1'b1, 1'b0));
        // Tnew equal to Tuse: forwarding suffices, no stall.
        set_data(5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 5'd0, 2'd1, 2'd0);
        cycle("tnew_eq", vec(1'b0, 1'b0));
        // Tuse 3 = never used.
        set_data(5'd7, 5'd7, 2'd3, 2'd3, 5'd7, 5'd7, 2'd3, 2'd3);
        cycle("tuse_never", vec(1'b0, 1'b0));

        // Random data hazards; mult/div idle so only data stalls apply.
        for (int i = 0; i < 40; i++) begin
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
            ed = 5'($urandom_range(0, 3)); md = 5'($urandom_range(0, 3));
            urs = 2'($urandom_range(0, 3)); urt = 2'($urandom_range(0, 3));
            te = 2'($urandom_range(0, 3)); tm = 2'($urandom_range(0, 3));
            set_data(rs, rt, urs, urt, ed, md, te, tm);
            set_md(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            cycle("rand_data", vec(ref_stall(rs, rt, urs, urt, ed, md, te, tm), 1'b0));
        end
        check("cnt_rand", stall_cnt, cnt_exp());

        // Div followed by a held HI/LO reader: 1 + 10 stall cycles.
        set_data(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0);
        seen_stalls = 0;
        set_md(1'b1, 1'b1, 1'b1);
        cycle("div_start", vec(1'b1, 1'b0));
        check("div_dbg", 32'(dbg_state), 32'd1);
        set_md(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("div_busy", vec(1'b1, 1'b1));
        cycle("div_done", vec(1'b0, 1'b0));
        check("div_stalls", 32'(seen_stalls), 32'd11);
        check("cnt_div", stall_cnt, cnt_exp());

        // Mult with a second start while busy: ignored, still 5 busy cycles.
        set_md(1'b0, 1'b1, 1'b0);
        cycle("mul_start", vec(1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            set_md(1'b0, (i == 1), 1'b1);
            cycle("mul_busy", vec(1'b0, 1'b1));
        end
        set_md(1'b0, 1'b0, 1'b0);
        cycle("mul_done", vec(1'b0, 1'b0));

        // Reset two cycles after a mult start abandons it.
        set_md(1'b0, 1'b1, 1'b0);
        cycle("rm_start", vec(1'b0, 1'b0));
        set_md(1'b0, 1'b0, 1'b0);
        cycle("rm_busy", vec(1'b0, 1'b1));
        reset = 1'b1;
        set_md(1'b1, 1'b0, 1'b0);
        cycle("rm_reset", vec(1'b0, 1'b0));
        reset = 1'b0;
        cycle("rm_after", vec(1'b0, 1'b0));
        check("rm_cnt", stall_cnt, 32'd0);
        set_md(1'b0, 1'b0, 1'b0);

        // 3 data stalls, then a 6-cycle mult stall with one coinciding data stall.
        set_data(5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 5'd0, 2'd2, 2'd0);
        for (int i = 0; i < 3; i++) cycle("st_data", vec(1'b1, 1'b0));
        set_data(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0);
        set_md(1'b1, 1'b1, 1'b0);
        cycle("st_md_start", vec(1'b1, 1'b0));
        set_md(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) set_data(5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 5'd0, 2'd2, 2'd0);
            else        set_data(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0);
            cycle("st_md_busy", vec(1'b1, 1'b1));
        end
        set_data(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0);
        set_md(1'b0, 1'b0, 1'b0);
        cycle("st_idle", vec(1'b0, 1'b0));
        check("st_cnt9", stall_cnt, STATS ? 32'd9 : 32'd0);

`ifdef HAZARD_STATS_EN
        // Wrap from all-ones to zero.
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        check("st_preload", stall_cnt, 32'hFFFF_FFFF);
        set_data(5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 5'd0, 2'd2, 2'd0);
        cycle("st_wrap_stall", vec(1'b1, 1'b0));
        check("st_wrap", stall_cnt, 32'd0);
        check("st_wrap_model", stall_cnt, exp_cnt);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
